// File: rtl/dcache_ctrl.sv
// Direct-mapped-per-request data cache controller: zero-wait hits, write-back
// of dirty victims, line refill from memory, then replay of the held request.
// Optional feature macro: DCACHE_PERF_CNT_EN adds hit/miss event counters.
module dcache_ctrl (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [31:0]  cpu_addr_i,
  input  logic [31:0]  cpu_data_i,
  input  logic         cpu_MemRead_i,
  input  logic         cpu_MemWrite_i,
  output logic [31:0]  cpu_data_o,
  output logic         cpu_stall_o,
  output logic [3:0]   sram_addr_o,
  output logic [24:0]  sram_tag_o,
  output logic [255:0] sram_data_o,
  output logic         sram_enable_o,
  output logic         sram_write_o,
  input  logic [24:0]  sram_tag_i,
  input  logic [255:0] sram_data_i,
  input  logic         sram_hit_i,
  output logic [31:0]  mem_addr_o,
  output logic [255:0] mem_data_o,
  output logic         mem_enable_o,
  output logic         mem_write_o,
  input  logic [255:0] mem_data_i,
  input  logic         mem_ack_i
`ifdef DCACHE_PERF_CNT_EN
  ,
  output logic [31:0]  hit_cnt_o,
  output logic [31:0]  miss_cnt_o
`endif
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    MISS       = 3'd1,
    WRITEBACK  = 3'd2,
    READMISS   = 3'd3,
    READMISSOK = 3'd4
  } state_e;

  state_e         state_q, state_d;
  logic           mem_en_q, mem_en_d;
  logic           mem_we_q, mem_we_d;
  logic [31:0]    mem_addr_q, mem_addr_d;
  logic [255:0]   mem_data_q, mem_data_d;
  logic [255:0]   merged_line;

  logic           req;
  logic [22:0]    cpu_tag;
  logic [3:0]     index;
  logic [2:0]     word;
  logic           victim_dirty;
  logic [1:0]     unused_byte_sel;

  assign req             = cpu_MemRead_i | cpu_MemWrite_i;
  assign cpu_tag         = cpu_addr_i[31:9];
  assign index           = cpu_addr_i[8:5];
  assign word            = cpu_addr_i[4:2];
  assign unused_byte_sel = cpu_addr_i[1:0];
  assign victim_dirty    = sram_tag_i[24] & sram_tag_i[23];

  assign sram_addr_o  = index;
  assign mem_enable_o = mem_en_q;
  assign mem_write_o  = mem_we_q;
  assign mem_addr_o   = mem_addr_q;
  assign mem_data_o   = mem_data_q;

  // State and memory-request registers; the memory request is held stable until acked.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q    <= IDLE;
      mem_en_q   <= 1'b0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
    end else begin
      state_q    <= state_d;
      mem_en_q   <= mem_en_d;
      mem_we_q   <= mem_we_d;
      mem_addr_q <= mem_addr_d;
      mem_data_q <= mem_data_d;
    end
  end

  // Next-state, SRAM port control and CPU handshake.
  always_comb begin
    state_d       = state_q;
    mem_en_d      = mem_en_q;
    mem_we_d      = mem_we_q;
    mem_addr_d    = mem_addr_q;
    mem_data_d    = mem_data_q;
    sram_enable_o = 1'b1;
    sram_write_o  = 1'b0;
    sram_tag_o    = {2'b00, cpu_tag};
    sram_data_o   = sram_data_i;
    cpu_stall_o   = 1'b1;

    merged_line = sram_data_i;
    merged_line[{word, 5'b0} +: 32] = cpu_data_i;

    unique case (state_q)
      IDLE: begin
        sram_enable_o = req;
        cpu_stall_o   = req & ~sram_hit_i;
        if (req) begin
          if (sram_hit_i) begin
            // A store wins when both request lines are high.
            if (cpu_MemWrite_i) begin
              sram_write_o = 1'b1;
              sram_data_o  = merged_line;
              sram_tag_o   = {2'b11, cpu_tag};
            end
          end else begin
            state_d = MISS;
          end
        end
      end
      MISS: begin
        mem_en_d = 1'b1;
        if (victim_dirty) begin
          mem_we_d   = 1'b1;
          mem_addr_d = {sram_tag_i[22:0], index, 5'b0};
          mem_data_d = sram_data_i;
          state_d    = WRITEBACK;
        end else begin
          mem_we_d   = 1'b0;
          mem_addr_d = {cpu_addr_i[31:5], 5'b0};
          state_d    = READMISS;
        end
      end
      WRITEBACK: begin
        if (mem_ack_i) begin
          mem_we_d   = 1'b0;
          mem_addr_d = {cpu_addr_i[31:5], 5'b0};
          state_d    = READMISS;
        end
      end
      READMISS: begin
        if (mem_ack_i) begin
          mem_en_d     = 1'b0;
          mem_we_d     = 1'b0;
          sram_write_o = 1'b1;
          sram_data_o  = mem_data_i;
          sram_tag_o   = {1'b1, 1'b0, cpu_tag};
          state_d      = READMISSOK;
        end
      end
      READMISSOK: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    cpu_data_o = sram_enable_o ? sram_data_i[{word, 5'b0} +: 32] : '0;
  end

`ifdef DCACHE_PERF_CNT_EN
  logic idle_hit, idle_miss;
  logic [31:0] hit_cnt_q, miss_cnt_q;

  assign idle_hit   = (state_q == IDLE) & req & sram_hit_i;
  assign idle_miss  = (state_q == IDLE) & req & ~sram_hit_i;
  assign hit_cnt_o  = hit_cnt_q;
  assign miss_cnt_o = miss_cnt_q;

  // Free-running wrap-around event counters for hits and miss entries.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (idle_hit)  hit_cnt_q  <= hit_cnt_q + 32'd1;
      if (idle_miss) miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed bench for dcache_ctrl with a one-way SRAM stub and a fixed-latency memory.
module tb_dcache_ctrl;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic [31:0]  cpu_addr_i;
  logic [31:0]  cpu_data_i;
  logic         cpu_MemRead_i;
  logic         cpu_MemWrite_i;
  logic [31:0]  cpu_data_o;
  logic         cpu_stall_o;
  logic [3:0]   sram_addr_o;
  logic [24:0]  sram_tag_o;
  logic [255:0] sram_data_o;
  logic         sram_enable_o;
  logic         sram_write_o;
  logic [24:0]  sram_tag_i;
  logic [255:0] sram_data_i;
  logic         sram_hit_i;
  logic [31:0]  mem_addr_o;
  logic [255:0] mem_data_o;
  logic         mem_enable_o;
  logic         mem_write_o;
  logic [255:0] mem_data_i;
  logic         mem_ack_i;
`ifdef DCACHE_PERF_CNT_EN
  logic [31:0]  hit_cnt_o;
  logic [31:0]  miss_cnt_o;
`endif

  dcache_ctrl dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .cpu_addr_i     (cpu_addr_i),
    .cpu_data_i     (cpu_data_i),
    .cpu_MemRead_i  (cpu_MemRead_i),
    .cpu_MemWrite_i (cpu_MemWrite_i),
    .cpu_data_o     (cpu_data_o),
    .cpu_stall_o    (cpu_stall_o),
    .sram_addr_o    (sram_addr_o),
    .sram_tag_o     (sram_tag_o),
    .sram_data_o    (sram_data_o),
    .sram_enable_o  (sram_enable_o),
    .sram_write_o   (sram_write_o),
    .sram_tag_i     (sram_tag_i),
    .sram_data_i    (sram_data_i),
    .sram_hit_i     (sram_hit_i),
    .mem_addr_o     (mem_addr_o),
    .mem_data_o     (mem_data_o),
    .mem_enable_o   (mem_enable_o),
    .mem_write_o    (mem_write_o),
    .mem_data_i     (mem_data_i),
    .mem_ack_i      (mem_ack_i)
`ifdef DCACHE_PERF_CNT_EN
    ,
    .hit_cnt_o      (hit_cnt_o),
    .miss_cnt_o     (miss_cnt_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  int vectors = 0;
  int errors  = 0;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // SRAM stub: one line per set, lookup on the DUT's index/tag.
  logic [24:0]  tag_mem  [16];
  logic [255:0] data_mem [16];
  logic         preload_en = 1'b0;
  logic [3:0]   preload_idx;
  logic [24:0]  preload_tag;
  logic [255:0] preload_data;
  int           sram_wr_cnt = 0;

  always_comb begin
    sram_tag_i  = tag_mem[sram_addr_o];
    sram_data_i = data_mem[sram_addr_o];
    sram_hit_i  = sram_enable_o && tag_mem[sram_addr_o][24] &&
                  (tag_mem[sram_addr_o][22:0] == sram_tag_o[22:0]);
  end

  always @(posedge clk_i) begin
    if (!rst_i) begin
      for (int unsigned i = 0; i < 16; i++) begin
        tag_mem[i]  <= '0;
        data_mem[i] <= {8{32'hA5A5_0000 + i}};
      end
    end else if (preload_en) begin
      tag_mem[preload_idx]  <= preload_tag;
      data_mem[preload_idx] <= preload_data;
    end else if (sram_enable_o && sram_write_o) begin
      tag_mem[sram_addr_o]  <= sram_tag_o;
      data_mem[sram_addr_o] <= sram_data_o;
      sram_wr_cnt           <= sram_wr_cnt + 1;
    end
  end

  // Memory stub: acks on the 4th cycle of an enabled request; logs transactions.
  logic         auto_en   = 1'b1;
  logic         ack_force = 1'b0;
  logic [255:0] mem_line  = '0;
  int           mem_cnt   = 0;
  logic         log_we   [$];
  logic [31:0]  log_addr [$];
  logic [255:0] log_data [$];

  assign mem_ack_i  = ack_force | (auto_en & mem_enable_o & (mem_cnt == 3));
  assign mem_data_i = mem_line;

  always @(posedge clk_i) begin
    if (mem_ack_i && mem_enable_o) begin
      log_we.push_back(mem_write_o);
      log_addr.push_back(mem_addr_o);
      log_data.push_back(mem_data_o);
    end
    if (mem_ack_i || !mem_enable_o) mem_cnt <= 0;
    else                            mem_cnt <= mem_cnt + 1;
  end

  // Issue a request and wait until the DUT stops stalling; caller checks that cycle.
  task automatic access(input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [31:0] data, output int stalls);
    @(negedge clk_i);
    cpu_MemRead_i  = rd;
    cpu_MemWrite_i = wr;
    cpu_addr_i     = addr;
    cpu_data_i     = data;
    stalls = 0;
    #2;
    while (cpu_stall_o && stalls < 100) begin
      stalls++;
      @(negedge clk_i);
      #2;
    end
  endtask

  task automatic release_req();
    @(negedge clk_i);
    cpu_MemRead_i  = 1'b0;
    cpu_MemWrite_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int           stalls;
    int           base;
    int           wc;
    logic [255:0] line_a;
    logic [255:0] line_b;
    logic [255:0] victim;
    logic [255:0] exp_line;

    rst_i          = 1'b0;
    cpu_addr_i     = '0;
    cpu_data_i     = '0;
    cpu_MemRead_i  = 1'b0;
    cpu_MemWrite_i = 1'b0;

    // Reset state
    repeat (3) @(negedge clk_i);
    #2;
    chk("rst_mem_en",   {255'd0, mem_enable_o}, 256'd0);
    chk("rst_mem_we",   {255'd0, mem_write_o},  256'd0);
    chk("rst_mem_addr", {224'd0, mem_addr_o},   256'd0);
    chk("rst_mem_data", mem_data_o,             256'd0);
    chk("rst_stall",    {255'd0, cpu_stall_o},  256'd0);
    chk("rst_sram_en",  {255'd0, sram_enable_o}, 256'd0);
    chk("rst_cpu_data_gated", {224'd0, cpu_data_o}, 256'd0);
    @(negedge clk_i);
    rst_i = 1'b1;

    // Clean load miss at 0x124: read 0x120, 3 + 4 stall cycles, word1 returned
    line_a = {8{32'h1111_2222}};
    line_a[63:32] = 32'hDEAD_BEEF;
    mem_line = line_a;
    base = log_addr.size();
    access(1'b1, 1'b0, 32'h0000_0124, '0, stalls);
    chk("lm_stalls",   stalls, 7);
    chk("lm_data",     {224'd0, cpu_data_o}, {224'd0, 32'hDEAD_BEEF});
    chk("lm_ntrans",   log_addr.size() - base, 1);
    chk("lm_rd_we",    {255'd0, log_we[base]}, 256'd0);
    chk("lm_rd_addr",  {224'd0, log_addr[base]}, {224'd0, 32'h0000_0120});
    chk("lm_fill_tag", {231'd0, tag_mem[9]}, {231'd0, 25'h100_0000});
    chk("lm_mem_en_off", {255'd0, mem_enable_o}, 256'd0);
    release_req();

    // Store hit 0x124: write same cycle, only word1 replaced, dirty set, no stall
    exp_line = line_a;
    exp_line[63:32] = 32'h1234_5678;
    access(1'b0, 1'b1, 32'h0000_0124, 32'h1234_5678, stalls);
    chk("sh_stalls",   stalls, 0);
    chk("sh_wr",       {255'd0, sram_write_o}, {255'd0, 1'b1});
    chk("sh_line",     sram_data_o, exp_line);
    chk("sh_tag",      {231'd0, sram_tag_o}, {231'd0, 25'h180_0000});
    release_req();
    chk("sh_dirty_stored", {255'd0, tag_mem[9][23]}, {255'd0, 1'b1});

    // Dirty victim (tag 1) in set 9, load 0x52C: WRITE 0x320 then READ 0x520
    victim = {8{32'h7777_0001}};
    @(negedge clk_i);
    preload_idx  = 4'd9;
    preload_tag  = {2'b11, 23'h000001};
    preload_data = victim;
    preload_en   = 1'b1;
    @(negedge clk_i);
    preload_en = 1'b0;
    line_b = {8{32'h3333_4444}};
    line_b[127:96] = 32'h0BAD_F00D;
    mem_line = line_b;
    base = log_addr.size();
    access(1'b1, 1'b0, 32'h0000_052C, '0, stalls);
    chk("dm_stalls",   stalls, 11);
    chk("dm_data",     {224'd0, cpu_data_o}, {224'd0, 32'h0BAD_F00D});
    chk("dm_ntrans",   log_addr.size() - base, 2);
    chk("dm_wb_we",    {255'd0, log_we[base]}, {255'd0, 1'b1});
    chk("dm_wb_addr",  {224'd0, log_addr[base]}, {224'd0, 32'h0000_0320});
    chk("dm_wb_data",  log_data[base], victim);
    chk("dm_rd_we",    {255'd0, log_we[base+1]}, 256'd0);
    chk("dm_rd_addr",  {224'd0, log_addr[base+1]}, {224'd0, 32'h0000_0520});
    chk("dm_fill_tag", {231'd0, tag_mem[9]}, {231'd0, 25'h100_0002});
    release_req();

    // Read and write both high on a hit: treated as a store
    access(1'b1, 1'b1, 32'h0000_052C, 32'hCAFE_F00D, stalls);
    chk("rw_stalls",   stalls, 0);
    chk("rw_wr",       {255'd0, sram_write_o}, {255'd0, 1'b1});
    chk("rw_word",     {224'd0, sram_data_o[127:96]}, {224'd0, 32'hCAFE_F00D});
    chk("rw_dirty",    {254'd0, sram_tag_o[24:23]}, {254'd0, 2'b11});
    release_req();

`ifdef DCACHE_PERF_CNT_EN
    chk("cnt_hits",   {224'd0, hit_cnt_o},  {224'd0, 32'd4});
    chk("cnt_misses", {224'd0, miss_cnt_o}, {224'd0, 32'd2});
`endif

    // Reset while in READMISS, then a late ack: ignored, no SRAM write
    auto_en = 1'b0;
    @(negedge clk_i);
    cpu_MemRead_i = 1'b1;
    cpu_addr_i    = 32'h0000_0640;
    #2;
    chk("ra_stall_miss", {255'd0, cpu_stall_o}, {255'd0, 1'b1});
    @(negedge clk_i);
    @(negedge clk_i);
    chk("ra_mem_en",   {255'd0, mem_enable_o}, {255'd0, 1'b1});
    chk("ra_mem_addr", {224'd0, mem_addr_o}, {224'd0, 32'h0000_0640});
    wc   = sram_wr_cnt;
    base = log_addr.size();
    rst_i = 1'b0;
    @(negedge clk_i);
    rst_i          = 1'b1;
    cpu_MemRead_i  = 1'b0;
    ack_force      = 1'b1;
    #2;
    chk("ra_en_after_rst",  {255'd0, mem_enable_o}, 256'd0);
    chk("ra_stall_idle",    {255'd0, cpu_stall_o}, 256'd0);
    chk("ra_sram_wr_comb",  {255'd0, sram_write_o}, 256'd0);
    @(negedge clk_i);
    ack_force = 1'b0;
    chk("ra_no_sram_write", sram_wr_cnt, wc);
    chk("ra_no_mem_trans",  log_addr.size() - base, 0);
    chk("ra_en_final",      {255'd0, mem_enable_o}, 256'd0);
    chk("ra_addr_cleared",  {224'd0, mem_addr_o}, 256'd0);
`ifdef DCACHE_PERF_CNT_EN
    chk("cnt_hits_rst",   {224'd0, hit_cnt_o},  256'd0);
    chk("cnt_misses_rst", {224'd0, miss_cnt_o}, 256'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
